// File: rtl/store_lane_aligner.sv
// store_lane_aligner
// Registered store-data aligner between the execute stage and the data-memory
// port. A byte/half/word/dword operand is shifted onto its byte lanes and a
// matching byte-enable mask is produced. Handshakes are valid/ready on both
// sides.
//
// Build option: define MISALIGN_SPLIT_EN to split a store that straddles a
// bus-word boundary into two beats. Without it such a store is rejected with
// a one-cycle MISALIGN_ERR pulse, and the second-beat logic is not built.
module store_lane_aligner #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [1:0]          SIZE,
  input  logic [DATA_W-1:0]   DATA,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [ADDR_W-1:0]   OUT_ADDR,
  output logic [DATA_W-1:0]   OUT_DATA,
  output logic [DATA_W/8-1:0] OUT_BE,
  output logic                MISALIGN_ERR
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    ERR   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [NB-1:0]     out_be_q, out_be_d;

  // Request decode
  logic [OFF_W-1:0]  req_off;
  logic [3:0]        req_n;
  logic              req_illegal;
  logic              req_cross;
  logic              req_err;
  logic [DATA_W-1:0] req_masked;
  logic [NB-1:0]     req_low_be;
  logic [ADDR_W-1:0] req_base;
  logic [DATA_W-1:0] req_data0;
  logic [NB-1:0]     req_be0;
  logic              take_req;

`ifdef MISALIGN_SPLIT_EN
  logic [DATA_W-1:0]   beat1_data_q, beat1_data_d;
  logic [NB-1:0]       beat1_be_q, beat1_be_d;
  logic                cross_q, cross_d;
  logic [2*DATA_W-1:0] req_wide_data;
  logic [2*NB-1:0]     req_wide_be;
  logic [DATA_W-1:0]   req_data1;
  logic [NB-1:0]       req_be1;
`endif

  // Decode the incoming request: lane offset, size, legality and lane placement
  always_comb begin
    req_off     = ADDR[OFF_W-1:0];
    req_n       = 4'd1 << SIZE;
    req_illegal = 5'(req_n) > 5'(NB);
    req_cross   = (5'(req_off) + 5'(req_n)) > 5'(NB);
    req_masked  = '0;
    req_low_be  = '0;
    for (int i = 0; i < NB; i++) begin
      req_masked[8*i +: 8] = (i < int'(req_n)) ? DATA[8*i +: 8] : 8'h00;
      req_low_be[i]        = (i < int'(req_n));
    end
    req_base = {ADDR[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`ifdef MISALIGN_SPLIT_EN
    req_wide_data = {{DATA_W{1'b0}}, req_masked} << {req_off, 3'b000};
    req_wide_be   = {{NB{1'b0}}, req_low_be} << req_off;
    req_data0     = req_wide_data[DATA_W-1:0];
    req_data1     = req_wide_data[2*DATA_W-1:DATA_W];
    req_be0       = req_wide_be[NB-1:0];
    req_be1       = req_wide_be[2*NB-1:NB];
    req_err       = req_illegal;
`else
    req_data0 = req_masked << {req_off, 3'b000};
    req_be0   = req_low_be << req_off;
    req_err   = req_illegal | req_cross;
`endif
  end

  // Next-state, handshake and beat-load logic
  always_comb begin
    state_d    = state_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_be_d   = out_be_q;
    IN_READY   = 1'b0;
    take_req   = 1'b0;
`ifdef MISALIGN_SPLIT_EN
    beat1_data_d = beat1_data_q;
    beat1_be_d   = beat1_be_q;
    cross_d      = cross_q;
`endif

    case (state_q)
      IDLE: begin
        IN_READY = 1'b1;
        take_req = IN_VALID;
      end
      BEAT0: begin
`ifdef MISALIGN_SPLIT_EN
        IN_READY = OUT_READY & ~cross_q;
        if (OUT_READY) begin
          if (cross_q) begin
            state_d    = BEAT1;
            out_addr_d = out_addr_q + ADDR_W'(NB);
            out_data_d = beat1_data_q;
            out_be_d   = beat1_be_q;
          end else begin
            state_d  = IDLE;
            take_req = IN_VALID;
          end
        end
`else
        IN_READY = OUT_READY;
        if (OUT_READY) begin
          state_d  = IDLE;
          take_req = IN_VALID;
        end
`endif
      end
      BEAT1: begin
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take_req) begin
      if (req_err) begin
        state_d = ERR;
      end else begin
        state_d    = BEAT0;
        out_addr_d = req_base;
        out_data_d = req_data0;
        out_be_d   = req_be0;
`ifdef MISALIGN_SPLIT_EN
        beat1_data_d = req_data1;
        beat1_be_d   = req_be1;
        cross_d      = req_cross;
`endif
      end
    end
  end

  // State and beat registers; reset drops any pending beat immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_be_q   <= '0;
`ifdef MISALIGN_SPLIT_EN
      beat1_data_q <= '0;
      beat1_be_q   <= '0;
      cross_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_be_q   <= out_be_d;
`ifdef MISALIGN_SPLIT_EN
      beat1_data_q <= beat1_data_d;
      beat1_be_q   <= beat1_be_d;
      cross_q      <= cross_d;
`endif
    end
  end

  assign OUT_VALID    = (state_q == BEAT0) || (state_q == BEAT1);
  assign MISALIGN_ERR = (state_q == ERR);
  assign OUT_ADDR     = out_addr_q;
  assign OUT_DATA     = out_data_q;
  assign OUT_BE       = out_be_q;

endmodule
